// File: rtl/sram_arbiter_pkg.sv
// sram_arb_pkg: shared definitions for the SRAM arbiter slice.
//   state_e   - sequencer states (IDLE, ACCESS, TURN)
//   CNT_W     - width of the access-cycle down-counter
//   MAX_PORTS - largest supported requester count
//   IDX_W     - width of a port index / round-robin pointer (sized for MAX_PORTS)
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    TURN   = 2'd2
  } state_e;

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned MAX_PORTS = 8;
  localparam int unsigned IDX_W     = $clog2(MAX_PORTS);

endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: requester and SRAM pad bundle for sram_arbiter.
//   portReq/portWr/portAddr/portWdata - per-port request (port i at [i*W +: W])
//   portGnt/portRdata/portRvalid      - per-port grant pulse, read data, read-valid pulse
//   busy                              - arbiter not idle
//   sramAddr/sramDataOut/sramDataOe/sramWr/sramEn - pad drive, sramDataIn - pad return
// Modports: slave = arbiter view, master = requester/pad view.
interface sram_arbiter_if #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16
);

  logic [NUM_PORTS-1:0]        portReq;
  logic [NUM_PORTS-1:0]        portWr;
  logic [NUM_PORTS*ADDR_W-1:0] portAddr;
  logic [NUM_PORTS*DATA_W-1:0] portWdata;
  logic [NUM_PORTS-1:0]        portGnt;
  logic [NUM_PORTS*DATA_W-1:0] portRdata;
  logic [NUM_PORTS-1:0]        portRvalid;
  logic                        busy;
  logic [ADDR_W-1:0]           sramAddr;
  logic [DATA_W-1:0]           sramDataOut;
  logic [DATA_W-1:0]           sramDataIn;
  logic                        sramDataOe;
  logic                        sramWr;
  logic                        sramEn;

  modport slave (
    input  portReq, portWr, portAddr, portWdata, sramDataIn,
    output portGnt, portRdata, portRvalid, busy,
           sramAddr, sramDataOut, sramDataOe, sramWr, sramEn
  );

  modport master (
    output portReq, portWr, portAddr, portWdata, sramDataIn,
    input  portGnt, portRdata, portRvalid, busy,
           sramAddr, sramDataOut, sramDataOe, sramWr, sramEn
  );

endinterface

// File: rtl/sram_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req - request vector, ptr - last winner
//   gnt - one-hot winner, idx - winner index
// Search starts at ptr+1 and wraps modulo NUM_PORTS.
// With SRAM_ARB_PRIORITY_EN defined, port 0 overrides the rotation whenever it requests.
module rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [IDX_W-1:0]     idx
);

  int unsigned cand;
  logic        found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      cand = (32'(ptr) + k) % NUM_PORTS;
      for (int unsigned j = 0; j < NUM_PORTS; j++) begin
        if (!found && (j == cand) && req[j]) begin
          found  = 1'b1;
          gnt[j] = 1'b1;
          idx    = IDX_W'(j);
        end
      end
    end
`ifdef SRAM_ARB_PRIORITY_EN
    if (req[0]) begin
      gnt    = '0;
      gnt[0] = 1'b1;
      idx    = '0;
    end
`endif
  end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one external SRAM among NUM_PORTS requesters.
//   clk  - rising-edge clock
//   rstn - asynchronous active-low reset
//   bus  - sram_arbiter_if.slave (requests, grants, read data, SRAM pad drive)
// One transaction at a time: IDLE -> ACCESS (ACCESS_CYCLES cycles) -> IDLE for
// reads, with an extra TURN cycle after writes for bus turnaround.
// Optional macro SRAM_ARB_PRIORITY_EN: port 0 always wins; only grants to
// ports >= 1 advance the round-robin pointer.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS     = 2,
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned ACCESS_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rstn,
  sram_arbiter_if.slave   bus
);

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]            ptr_q, ptr_d;
  logic [IDX_W-1:0]            win_q, win_d;
  logic                        wr_q, wr_d;
  logic [NUM_PORTS-1:0]        gnt_q, gnt_d;
  logic [NUM_PORTS-1:0]        rvalid_q, rvalid_d;
  logic [NUM_PORTS*DATA_W-1:0] rdata_q, rdata_d;
  logic                        busy_q, busy_d;
  logic [ADDR_W-1:0]           sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0]           sram_dout_q, sram_dout_d;
  logic                        sram_oe_q, sram_oe_d;
  logic                        sram_wr_q, sram_wr_d;
  logic                        sram_en_q, sram_en_d;

  logic [NUM_PORTS-1:0]        pick_gnt;
  logic [IDX_W-1:0]            pick_idx;
  logic                        sel_wr;
  logic [ADDR_W-1:0]           sel_addr;
  logic [DATA_W-1:0]           sel_wdata;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
    .req (bus.portReq),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Winner's request fields.
  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (IDX_W'(i) == pick_idx) begin
        sel_wr    = bus.portWr[i];
        sel_addr  = bus.portAddr[i*ADDR_W +: ADDR_W];
        sel_wdata = bus.portWdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    wr_d        = wr_q;
    gnt_d       = '0;
    rvalid_d    = '0;
    rdata_d     = rdata_q;
    sram_addr_d = sram_addr_q;
    sram_dout_d = sram_dout_q;
    sram_oe_d   = sram_oe_q;
    sram_wr_d   = sram_wr_q;
    sram_en_d   = sram_en_q;

    case (state_q)
      IDLE: begin
        sram_addr_d = '0;
        sram_dout_d = '0;
        sram_oe_d   = 1'b0;
        sram_wr_d   = 1'b0;
        sram_en_d   = 1'b0;
        if (|bus.portReq) begin
          state_d     = ACCESS;
          cnt_d       = CNT_W'(ACCESS_CYCLES - 1);
          win_d       = pick_idx;
          wr_d        = sel_wr;
          gnt_d       = pick_gnt;
`ifdef SRAM_ARB_PRIORITY_EN
          if (pick_idx != '0) ptr_d = pick_idx;
`else
          ptr_d       = pick_idx;
`endif
          sram_en_d   = 1'b1;
          sram_addr_d = sel_addr;
          sram_wr_d   = sel_wr;
          sram_oe_d   = sel_wr;
          sram_dout_d = sel_wr ? sel_wdata : '0;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          sram_addr_d = '0;
          sram_dout_d = '0;
          sram_oe_d   = 1'b0;
          sram_wr_d   = 1'b0;
          sram_en_d   = 1'b0;
          if (wr_q) begin
            state_d = TURN;
          end else begin
            state_d = IDLE;
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
              if (IDX_W'(i) == win_q) begin
                rdata_d[i*DATA_W +: DATA_W] = bus.sramDataIn;
                rvalid_d[i]                 = 1'b1;
              end
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      TURN: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        sram_addr_d = '0;
        sram_dout_d = '0;
        sram_oe_d   = 1'b0;
        sram_wr_d   = 1'b0;
        sram_en_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= IDX_W'(NUM_PORTS - 1);
      win_q       <= '0;
      wr_q        <= 1'b0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      sram_addr_q <= '0;
      sram_dout_q <= '0;
      sram_oe_q   <= 1'b0;
      sram_wr_q   <= 1'b0;
      sram_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      wr_q        <= wr_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      sram_addr_q <= sram_addr_d;
      sram_dout_q <= sram_dout_d;
      sram_oe_q   <= sram_oe_d;
      sram_wr_q   <= sram_wr_d;
      sram_en_q   <= sram_en_d;
    end
  end

  assign bus.portGnt     = gnt_q;
  assign bus.portRvalid  = rvalid_q;
  assign bus.portRdata   = rdata_q;
  assign bus.busy        = busy_q;
  assign bus.sramAddr    = sram_addr_q;
  assign bus.sramDataOut = sram_dout_q;
  assign bus.sramDataOe  = sram_oe_q;
  assign bus.sramWr      = sram_wr_q;
  assign bus.sramEn      = sram_en_q;

endmodule
